inference_sequencer: RTL and testbench

Top-level layer scheduler for the CNN accelerator. It accepts one frame at a time and launches the compute stages in fixed order: conv, relu/pool, flatten, dense. Each stage uses a single-cycle start/done pulse handshake. After the final dense stage completes, the block scans its OUT_DIM logits serially and returns the winning class through a valid/ready result interface. A per-stage watchdog flags stalled stages and reports which stage failed.

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/inference_sequencer_argmax_serial.sv | 83 ++++++++
 rtl/inference_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_inference_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator control path.
//   - seq_state_t    : layer sequencer FSM states
//   - DEF_*          : default datapath sizes
//   - STG_*          : stage indices in launch order
//   - clog2_min1()   : index width helper that never returns 0
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_OUT_DIM    = 10;
  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_TIMEOUT    = 1 << 20;

  localparam int STG_CONV  = 0;
  localparam int STG_POOL  = 1;
  localparam int STG_FLAT  = 2;
  localparam int STG_DENSE = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_ARGMAX = 3'd3,
    S_RESULT = 3'd4,
    S_ERROR  = 3'd5
  } seq_state_t;

  // Index width for a range of v entries; a single entry still needs one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/inference_sequencer_argmax_serial.sv
// argmax_serial: serial argmax over OUT_DIM signed logits, one compare per cycle.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : pulse; seeds best=logits[0], idx=0 and begins scanning k=1..
//   logits      : OUT_DIM packed signed values, logit k at [k*DATA_WIDTH +: DATA_WIDTH]
//   done        : high in the cycle the last logit is evaluated (with start if OUT_DIM=1)
//   class_idx   : winning index including this cycle's compare (valid with done)
//   score       : winning value including this cycle's compare (valid with done)
// Strict greater-than means ties keep the lowest index.
module argmax_serial
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_DIM    = DEF_OUT_DIM,
  parameter int CLASS_W    = clog2_min1(OUT_DIM)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [OUT_DIM*DATA_WIDTH-1:0] logits,
  output logic                          done,
  output logic [CLASS_W-1:0]            class_idx,
  output logic signed [DATA_WIDTH-1:0]  score
);

  logic signed [DATA_WIDTH-1:0] lg [OUT_DIM];

  logic                         run_q, run_d;
  logic [CLASS_W-1:0]           k_q, k_d;
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic [CLASS_W-1:0]           idx_q, idx_d;

  always_comb begin
    for (int i = 0; i < OUT_DIM; i++) begin
      lg[i] = logits[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    run_d  = run_q;
    k_d    = k_q;
    best_d = best_q;
    idx_d  = idx_q;
    done   = 1'b0;
    if (start) begin
      best_d = lg[0];
      idx_d  = '0;
      k_d    = CLASS_W'(1);
      run_d  = (OUT_DIM > 1);
      done   = (OUT_DIM == 1);
    end else if (run_q) begin
      if (lg[k_q] > best_q) begin
        best_d = lg[k_q];
        idx_d  = k_q;
      end
      if (k_q == CLASS_W'(OUT_DIM - 1)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end else begin
        k_d = k_q + CLASS_W'(1);
      end
    end
  end

  // Results include the current compare so the caller can latch them with done.
  assign class_idx = idx_d;
  assign score     = best_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 1'b0;
      k_q    <= '0;
      best_q <= '0;
      idx_q  <= '0;
    end else begin
      run_q  <= run_d;
      k_q    <= k_d;
      best_q <= best_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: frame-level layer scheduler for the CNN accelerator.
// Launches stages 0..NUM_STAGES-1 in order, then scans the final stage's
// logits serially and presents the winning class.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   frame_valid/ready     : frame accept; ready only in IDLE
//   stage_start[k]        : registered one-cycle start pulse to stage k
//   stage_done[k]         : one-cycle done pulse from stage k
//   logits                : OUT_DIM packed signed logits from the last stage
//   result_valid/ready    : result handshake (class, score, frame_cycles)
//   busy                  : high outside IDLE
//   error, error_stage    : sticky watchdog flag and the stalled stage index
//   clear_err             : leaves ERROR back to IDLE
//   dbg_state             : current FSM state (seq_state_t encoding)
// Handshakes: result is transferred on the cycle where result_valid and
// result_ready are both high; result_valid then drops and its payload stays
// stable while result_valid is high. Frames transfer when frame_valid is high
// while frame_ready is high. Stage start/done are single-cycle pulses.
module inference_sequencer
  import cnn_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OUT_DIM        = DEF_OUT_DIM,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int CLASS_W        = clog2_min1(OUT_DIM),
  parameter int STAGE_W        = clog2_min1(NUM_STAGES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_valid,
  output logic                          frame_ready,
  output logic [NUM_STAGES-1:0]         stage_start,
  input  logic [NUM_STAGES-1:0]         stage_done,
  input  logic [OUT_DIM*DATA_WIDTH-1:0] logits,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [CLASS_W-1:0]            result_class,
  output logic signed [DATA_WIDTH-1:0]  result_score,
  output logic [31:0]                   frame_cycles,
  output logic                          busy,
  output logic                          error,
  output logic [STAGE_W-1:0]            error_stage,
  input  logic                          clear_err,
  output logic [2:0]                    dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  seq_state_t                   state_q, state_d;
  logic [STAGE_W-1:0]           stage_q, stage_d;
  logic [NUM_STAGES-1:0]        stage_start_q, stage_start_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic [31:0]                  cnt_q, cnt_d;
  logic [31:0]                  cnt_inc;
  logic                         result_valid_q, result_valid_d;
  logic [CLASS_W-1:0]           result_class_q, result_class_d;
  logic signed [DATA_WIDTH-1:0] result_score_q, result_score_d;
  logic [31:0]                  frame_cycles_q, frame_cycles_d;
  logic                         error_q, error_d;
  logic [STAGE_W-1:0]           error_stage_q, error_stage_d;

  logic                         am_start;
  logic                         am_done;
  logic [CLASS_W-1:0]           am_class;
  logic signed [DATA_WIDTH-1:0] am_score;

  argmax_serial #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_DIM    (OUT_DIM),
    .CLASS_W    (CLASS_W)
  ) u_argmax (
    .clk       (clk),
    .reset     (reset),
    .start     (am_start),
    .logits    (logits),
    .done      (am_done),
    .class_idx (am_class),
    .score     (am_score)
  );

  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_comb begin
    state_d        = state_q;
    stage_d        = stage_q;
    stage_start_d  = '0;
    timer_d        = timer_q;
    cnt_d          = cnt_q;
    result_valid_d = result_valid_q;
    result_class_d = result_class_q;
    result_score_d = result_score_q;
    frame_cycles_d = frame_cycles_q;
    error_d        = error_q;
    error_stage_d  = error_stage_q;
    am_start       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          stage_d       = '0;
          // The accept cycle is counted, so frame_cycles equals the cycle
          // distance from the accept cycle to the first RESULT cycle.
          cnt_d         = 32'd1;
          stage_start_d = NUM_STAGES'(1);
          state_d       = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        timer_d = '0;
        cnt_d   = cnt_inc;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_inc;
        // Done is checked before the watchdog so a coincident done wins.
        if (stage_done[stage_q]) begin
          if (stage_q == LAST_STAGE) begin
            am_start = 1'b1;
            if (am_done) begin
              result_valid_d = 1'b1;
              result_class_d = am_class;
              result_score_d = am_score;
              frame_cycles_d = cnt_inc;
              state_d        = S_RESULT;
            end else begin
              state_d = S_ARGMAX;
            end
          end else begin
            stage_d       = stage_q + STAGE_W'(1);
            stage_start_d = NUM_STAGES'(1) << (stage_q + STAGE_W'(1));
            state_d       = S_LAUNCH;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          error_d       = 1'b1;
          error_stage_d = stage_q;
          state_d       = S_ERROR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_ARGMAX: begin
        cnt_d = cnt_inc;
        if (am_done) begin
          result_valid_d = 1'b1;
          result_class_d = am_class;
          result_score_d = am_score;
          frame_cycles_d = cnt_inc;
          state_d        = S_RESULT;
        end
      end

      S_RESULT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end

      S_ERROR: begin
        if (clear_err) begin
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      stage_q        <= '0;
      stage_start_q  <= '0;
      timer_q        <= '0;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      result_score_q <= '0;
      frame_cycles_q <= '0;
      error_q        <= 1'b0;
      error_stage_q  <= '0;
    end else begin
      state_q        <= state_d;
      stage_q        <= stage_d;
      stage_start_q  <= stage_start_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      result_valid_q <= result_valid_d;
      result_class_q <= result_class_d;
      result_score_q <= result_score_d;
      frame_cycles_q <= frame_cycles_d;
      error_q        <= error_d;
      error_stage_q  <= error_stage_d;
    end
  end

  // frame_ready is a decode of IDLE, masked while reset is held so every
  // output reads 0 during reset.
  assign frame_ready  = (state_q == S_IDLE) && !reset;
  assign busy         = (state_q != S_IDLE);
  assign stage_start  = stage_start_q;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign result_score = result_score_q;
  assign frame_cycles = frame_cycles_q;
  assign error        = error_q;
  assign error_stage  = error_stage_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_inference_sequencer.sv
module tb_inference_sequencer;

  localparam int NS = 4;
  localparam int DW = 16;
  localparam int OD = 10;
  localparam int TO = 64;
  localparam int CW = 4;
  localparam int SW = 2;

  logic                   clk;
  logic                   reset;
  logic                   frame_valid;
  logic                   frame_ready;
  logic [NS-1:0]          stage_start;
  logic [NS-1:0]          stage_done;
  logic [OD*DW-1:0]       logits;
  logic                   result_valid;
  logic                   result_ready;
  logic [CW-1:0]          result_class;
  logic signed [DW-1:0]   result_score;
  logic [31:0]            frame_cycles;
  logic                   busy;
  logic                   error;
  logic [SW-1:0]          error_stage;
  logic                   clear_err;
  logic [2:0]             dbg_state;

  inference_sequencer #(
    .NUM_STAGES     (NS),
    .DATA_WIDTH     (DW),
    .OUT_DIM        (OD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .stage_start  (stage_start),
    .stage_done   (stage_done),
    .logits       (logits),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_score (result_score),
    .frame_cycles (frame_cycles),
    .busy         (busy),
    .error        (error),
    .error_stage  (error_stage),
    .clear_err    (clear_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stage model / start scoreboard ----------------
  int              dly [NS];     // done delay after start; 0 = never completes
  bit              spur_en;
  int              pend_cnt = 0;
  int              pend_idx = 0;
  int              spur_cnt = 0;
  logic [3:0]      exp_q [$];    // expected start order

  always @(negedge clk) begin
    int idx;
    stage_done = '0;
    if (reset) begin
      pend_cnt = 0;
      spur_cnt = 0;
    end else begin
      if (spur_cnt > 0) begin
        spur_cnt--;
        if (spur_cnt == 0) stage_done[3] = 1'b1;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) stage_done[pend_idx] = 1'b1;
      end
      if (stage_start != '0) begin
        idx = 0;
        for (int i = 0; i < NS; i++) if (stage_start[i]) idx = i;
        check_val("start_onehot", 64'($countones(stage_start)), 64'd1);
        check_val("start_order", 64'(idx), 64'((exp_q.size() > 0) ? exp_q.pop_front() : 4'hF));
        if (dly[idx] > 0) begin
          pend_idx = idx;
          pend_cnt = dly[idx];
        end
        if (spur_en && idx == 1) spur_cnt = 1;
      end
    end
  end

  // ---------------- reference model ----------------
  logic signed [DW-1:0] lg [OD];
  logic [CW-1:0]        m_class;
  logic signed [DW-1:0] m_score;
  int                   m_cycles;

  task automatic model_frame();
    m_class = '0;
    m_score = lg[0];
    for (int k = 1; k < OD; k++) begin
      if (lg[k] > m_score) begin
        m_score = lg[k];
        m_class = CW'(k);
      end
    end
    // accept cycle + (launch + wait) per stage + one cycle per remaining logit
    m_cycles = 1 + (OD - 1);
    for (int s = 0; s < NS; s++) m_cycles += 1 + dly[s];
  endtask

  task automatic pack_logits();
    for (int k = 0; k < OD; k++) logits[k*DW +: DW] = lg[k];
  endtask

  task automatic rand_logits();
    int v;
    for (int k = 0; k < OD; k++) begin
      if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 6)) - 3;
      else v = int'($urandom_range(0, 65535));
      lg[k] = DW'(v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic accept_frame();
    int n;
    n = 0;
    while (!frame_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("frame_ready_before_accept", 64'(frame_ready), 64'd1);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    check_val("launch_latency", 64'(stage_start), 64'd1);
  endtask

  task automatic run_frame(input int hold);
    int t;
    model_frame();
    pack_logits();
    exp_q.delete();
    for (int s = 0; s < NS; s++) exp_q.push_back(4'(s));
    accept_frame();
    t = 1;
    while (!result_valid && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_val("result_valid", 64'(result_valid), 64'd1);
    check_val("accept_to_result", 64'(t), 64'(m_cycles));
    check_val("result_class", 64'(result_class), 64'(m_class));
    check_val("result_score", 64'(result_score), 64'(m_score));
    check_val("frame_cycles", 64'(frame_cycles), 64'(m_cycles));
    check_val("busy_in_result", 64'(busy), 64'd1);
    check_val("starts_left", 64'(exp_q.size()), 64'd0);
    if (hold > 0) frame_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("bp_valid", 64'(result_valid), 64'd1);
      check_val("bp_class", 64'(result_class), 64'(m_class));
      check_val("bp_score", 64'(result_score), 64'(m_score));
      check_val("bp_cycles", 64'(frame_cycles), 64'(m_cycles));
      check_val("bp_frame_ready", 64'(frame_ready), 64'd0);
      check_val("bp_no_start", 64'(stage_start), 64'd0);
    end
    result_ready = 1'b1;
    frame_valid  = 1'b0;
    @(negedge clk);
    result_ready = 1'b0;
    check_val("post_hs_valid", 64'(result_valid), 64'd0);
    check_val("post_hs_frame_ready", 64'(frame_ready), 64'd1);
    check_val("post_hs_busy", 64'(busy), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset        = 1'b1;
    frame_valid  = 1'b0;
    result_ready = 1'b0;
    clear_err    = 1'b0;
    logits       = '0;
    spur_en      = 1'b0;
    for (int s = 0; s < NS; s++) dly[s] = 1;
    repeat (3) @(negedge clk);
    check_val("rst_frame_ready", 64'(frame_ready), 64'd0);
    check_val("rst_start", 64'(stage_start), 64'd0);
    check_val("rst_valid", 64'(result_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_error", 64'(error), 64'd0);
    check_val("rst_cycles", 64'(frame_cycles), 64'd0);
    check_val("rst_class", 64'(result_class), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_frame_ready", 64'(frame_ready), 64'd1);
    check_val("post_rst_busy", 64'(busy), 64'd0);

    // nominal
    dly = '{5, 3, 7, 2};
    for (int k = 0; k < OD; k++) lg[k] = 16'h0010;
    lg[7] = 16'h0123;
    run_frame(0);

    // tie among negatives resolves to the lowest index
    dly = '{2, 2, 2, 2};
    for (int k = 0; k < OD; k++) lg[k] = -16'sd5;
    lg[2] = -16'sd1;
    lg[6] = -16'sd1;
    run_frame(0);

    // backpressure with a competing frame_valid
    dly = '{1, 4, 2, 3};
    rand_logits();
    run_frame(20);

    // spurious done on stage 3 while stage 1 is pending
    spur_en = 1'b1;
    dly = '{3, 6, 2, 2};
    rand_logits();
    run_frame(0);
    spur_en = 1'b0;

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      for (int s = 0; s < NS; s++) dly[s] = int'($urandom_range(1, 12));
      rand_logits();
      run_frame(int'($urandom_range(0, 3)));
    end

    // watchdog: stage 2 never completes
    dly = '{4, 3, 0, 2};
    rand_logits();
    pack_logits();
    exp_q.delete();
    for (int s = 0; s < 3; s++) exp_q.push_back(4'(s));
    accept_frame();
    n = 0;
    while (!stage_start[2] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("to_stage2_started", 64'(stage_start[2]), 64'd1);
    repeat (TO) @(negedge clk);
    check_val("to_error_not_early", 64'(error), 64'd0);
    @(negedge clk);
    check_val("to_error", 64'(error), 64'd1);
    check_val("to_error_stage", 64'(error_stage), 64'd2);
    check_val("to_busy", 64'(busy), 64'd1);
    check_val("to_frame_ready", 64'(frame_ready), 64'd0);
    check_val("to_valid", 64'(result_valid), 64'd0);
    repeat (5) @(negedge clk);
    check_val("to_error_sticky", 64'(error), 64'd1);
    check_val("to_starts_left", 64'(exp_q.size()), 64'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check_val("clr_error", 64'(error), 64'd0);
    check_val("clr_frame_ready", 64'(frame_ready), 64'd1);
    check_val("clr_busy", 64'(busy), 64'd0);

    // reset while stage 1 is in WAIT
    dly = '{3, 40, 2, 2};
    rand_logits();
    pack_logits();
    exp_q.delete();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    accept_frame();
    n = 0;
    while (!stage_start[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("mr_stage1_started", 64'(stage_start[1]), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("mr_start", 64'(stage_start), 64'd0);
    check_val("mr_busy", 64'(busy), 64'd0);
    check_val("mr_valid", 64'(result_valid), 64'd0);
    check_val("mr_error", 64'(error), 64'd0);
    check_val("mr_cycles", 64'(frame_cycles), 64'd0);
    check_val("mr_class", 64'(result_class), 64'd0);
    check_val("mr_score", 64'(result_score), 64'd0);
    reset = 1'b0;
    check_val("mr_starts_left", 64'(exp_q.size()), 64'd0);
    repeat (45) @(negedge clk);
    check_val("mr_idle_busy", 64'(busy), 64'd0);
    check_val("mr_idle_ready", 64'(frame_ready), 64'd1);
    dly = '{2, 5, 3, 4};
    rand_logits();
    run_frame(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
